// File: rtl/fsm_seq_generator.sv
// Serial pattern transmitter for the FSM sequence detectors: shifts a loaded
// pattern out MSB-first with optional repeat gaps and counts hits on the returned z line.
module fsm_seq_generator #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int CNT_W = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] pat_data,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] rep,
    input  logic             abort,
    input  logic             z,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int               GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [LEN_W-1:0] WIDTH_L  = LEN_W'(WIDTH);
    localparam logic [CNT_W-1:0] HIT_MAX  = '1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] pat_cap, pat_cap_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [LEN_W-1:0] len_cap, len_cap_next;
    logic [LEN_W-1:0] bit_cnt, bit_cnt_next;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_next;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_next;
    logic [CNT_W-1:0] hit_next;
    logic             x_next, x_valid_next, busy_next, done_next;
    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] aligned;

    assign start_ready = (state == S_IDLE);

    always_comb begin
        eff_len = pat_len;
        if (pat_len == '0 || pat_len > WIDTH_L)
            eff_len = WIDTH_L;
    end

    // Left-align the pattern so the first bit to send always sits in the MSB.
    assign aligned = pat_data << (WIDTH_L - eff_len);

    always_comb begin
        state_next   = state;
        pat_cap_next = pat_cap;
        shreg_next   = shreg;
        len_cap_next = len_cap;
        bit_cnt_next = bit_cnt;
        rep_cnt_next = rep_cnt;
        gap_cnt_next = gap_cnt;
        hit_next     = hit_cnt;
        x_next       = 1'b0;
        x_valid_next = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;

        if (busy && z && hit_cnt != HIT_MAX)
            hit_next = hit_cnt + CNT_W'(1);

        // shreg holds the bits still to be sent after the one currently on x.
        unique case (state)
            S_IDLE: begin
                if (start_valid) begin
                    state_next   = S_SHIFT;
                    pat_cap_next = aligned;
                    len_cap_next = eff_len;
                    rep_cnt_next = rep;
                    shreg_next   = aligned << 1;
                    bit_cnt_next = eff_len - LEN_W'(1);
                    hit_next     = '0;
                    x_next       = aligned[WIDTH-1];
                    x_valid_next = 1'b1;
                    busy_next    = 1'b1;
                end
            end
            S_SHIFT: begin
                busy_next = 1'b1;
                if (bit_cnt != '0) begin
                    shreg_next   = shreg << 1;
                    bit_cnt_next = bit_cnt - LEN_W'(1);
                    x_next       = shreg[WIDTH-1];
                    x_valid_next = 1'b1;
                end else if (rep_cnt == '0) begin
                    state_next = S_DONE;
                    done_next  = 1'b1;
                end else begin
                    rep_cnt_next = rep_cnt - CNT_W'(1);
                    if (GAP > 0) begin
                        state_next   = S_GAP;
                        gap_cnt_next = GAP_LAST;
                    end else begin
                        shreg_next   = pat_cap << 1;
                        bit_cnt_next = len_cap - LEN_W'(1);
                        x_next       = pat_cap[WIDTH-1];
                        x_valid_next = 1'b1;
                    end
                end
            end
            S_GAP: begin
                busy_next = 1'b1;
                if (gap_cnt == '0) begin
                    state_next   = S_SHIFT;
                    shreg_next   = pat_cap << 1;
                    bit_cnt_next = len_cap - LEN_W'(1);
                    x_next       = pat_cap[WIDTH-1];
                    x_valid_next = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        // Abort keeps the hit count but drops everything else back to idle.
        if (abort && state != S_IDLE) begin
            state_next   = S_IDLE;
            x_next       = 1'b0;
            x_valid_next = 1'b0;
            busy_next    = 1'b0;
            done_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            pat_cap <= '0;
            shreg   <= '0;
            len_cap <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            gap_cnt <= '0;
            hit_cnt <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            pat_cap <= pat_cap_next;
            shreg   <= shreg_next;
            len_cap <= len_cap_next;
            bit_cnt <= bit_cnt_next;
            rep_cnt <= rep_cnt_next;
            gap_cnt <= gap_cnt_next;
            hit_cnt <= hit_next;
            x       <= x_next;
            x_valid <= x_valid_next;
            busy    <= busy_next;
            done    <= done_next;
        end
    end

endmodule

// File: tb/tb_fsm_seq_generator.sv
// Scoreboard bench for fsm_seq_generator: three instances (back-to-back, GAP=2, 2-bit hit counter)
// exercised one at a time; a monitor pops expected bits and done pulses with their cycle numbers.
module tb_fsm_seq_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sv;
    logic [15:0] pat_data;
    logic [4:0]  pat_len;
    logic [7:0]  rep;
    logic        abort;
    logic [2:0]  sr, mx, mv, mb, md;
    logic [7:0]  hit0, hit1;
    logic [1:0]  hit2;
    logic [3:0]  win = '0;
    logic        z_det = 1'b0;

    int edges = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int dut;
        bit is_done;
        bit val;
        int cyc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    fsm_seq_generator #(.GAP(0)) u0 (
        .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(sr[0]),
        .pat_data(pat_data), .pat_len(pat_len), .rep(rep), .abort(abort), .z(z_det),
        .x(mx[0]), .x_valid(mv[0]), .busy(mb[0]), .done(md[0]), .hit_cnt(hit0)
    );

    fsm_seq_generator #(.GAP(2)) u1 (
        .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(sr[1]),
        .pat_data(pat_data), .pat_len(pat_len), .rep(rep), .abort(abort), .z(1'b0),
        .x(mx[1]), .x_valid(mv[1]), .busy(mb[1]), .done(md[1]), .hit_cnt(hit1)
    );

    fsm_seq_generator #(.CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .start_valid(sv[2]), .start_ready(sr[2]),
        .pat_data(pat_data), .pat_len(pat_len), .rep(rep[1:0]), .abort(abort), .z(1'b1),
        .x(mx[2]), .x_valid(mv[2]), .busy(mb[2]), .done(md[2]), .hit_cnt(hit2)
    );

    // Registered 1011 detector closing the loop on u0; its response lags the last bit by one cycle.
    always @(posedge clk) begin
        if (mv[0]) begin
            win   <= {win[2:0], mx[0]};
            z_det <= ({win[2:0], mx[0]} == 4'b1011);
        end else begin
            win   <= '0;
            z_det <= 1'b0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (mv[i] || md[i]) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected output: dut=%0d x=%0b done=%0b cycle=%0d, none required",
                             i, mx[i], md[i], edges);
                end else begin
                    e = sb.pop_front();
                    if (e.dut != i || e.is_done != md[i] || (!e.is_done && e.val != mx[i]) || e.cyc != edges) begin
                        bad++;
                        $display("[TB] FAIL stream: got dut=%0d done=%0b x=%0b cycle=%0d, want dut=%0d done=%0b x=%0b cycle=%0d",
                                 i, md[i], mx[i], edges, e.dut, e.is_done, e.val, e.cyc);
                    end
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic push_rep(input int dut, input logic [15:0] bits, input int len, input int c0);
        for (int j = 0; j < len; j++)
            sb.push_back(exp_t'{dut, 1'b0, bits[len-1-j], c0 + j});
    endtask

    task automatic push_done(input int dut, input int c);
        sb.push_back(exp_t'{dut, 1'b1, 1'b0, c});
    endtask

    // Called #1 after an edge; returns the edge number at which the start is accepted.
    task automatic apply_stimulus(input int dut, input logic [15:0] d, input logic [4:0] l,
                                  input logic [7:0] r, input logic ab, output int acc);
        pat_data = d;
        pat_len  = l;
        rep      = r;
        abort    = ab;
        sv[dut]  = 1'b1;
        acc      = edges + 1;
        @(posedge clk);
        #1;
        sv       = '0;
        abort    = 1'b0;
        pat_data = ~d;
        pat_len  = 5'd3;
        rep      = 8'd5;
    endtask

    initial begin
        int acc;
        rst = 1'b0; sv = '0; pat_data = '0; pat_len = '0; rep = '0; abort = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset x",          mx[0],   0);
        check_output("reset x_valid",    mv[0],   0);
        check_output("reset busy",       mb,      0);
        check_output("reset done",       md,      0);
        check_output("reset hit_cnt",    hit0,    0);
        check_output("reset start_ready", sr,     3'b111);

        // Single shot, started in the first cycle after reset release.
        rst = 1'b1;
        apply_stimulus(0, 16'h02E7, 5'd10, 8'd0, 1'b0, acc);
        push_rep(0, 16'h02E7, 10, acc);
        push_done(0, acc + 10);
        check_output("ready low while busy", sr[0], 0);
        repeat (11) @(posedge clk);
        #1;
        check_output("single ready back", sr[0], 1);
        check_output("single busy clear", mb[0], 0);
        check_output("single drain", sb.size(), 0);

        // Abort at the third bit.
        apply_stimulus(0, 16'h02E7, 5'd10, 8'd0, 1'b0, acc);
        push_rep(0, 16'h02E7 >> 7, 3, acc);
        repeat (2) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check_output("abort x_valid", mv[0], 0);
        check_output("abort busy",    mb[0], 0);
        check_output("abort ready",   sr[0], 1);
        repeat (3) @(posedge clk);
        #1 check_output("abort drain", sb.size(), 0);

        // Length clamp: 0 and 20 both send 16 bits; abort alongside start must not block it.
        apply_stimulus(0, 16'hA5C3, 5'd0, 8'd0, 1'b1, acc);
        push_rep(0, 16'hA5C3, 16, acc);
        push_done(0, acc + 16);
        repeat (17) @(posedge clk);
        #1 check_output("clamp0 ready", sr[0], 1);
        apply_stimulus(0, 16'h3C96, 5'd20, 8'd0, 1'b0, acc);
        push_rep(0, 16'h3C96, 16, acc);
        push_done(0, acc + 16);
        repeat (17) @(posedge clk);
        #1 check_output("clamp20 ready", sr[0], 1);
        check_output("clamp drain", sb.size(), 0);

        // Closed-loop hit counting with the 1011 detector over two repetitions.
        apply_stimulus(0, 16'h02DB, 5'd10, 8'd1, 1'b0, acc);
        push_rep(0, 16'h02DB, 10, acc);
        push_rep(0, 16'h02DB, 10, acc + 10);
        push_done(0, acc + 20);
        repeat (21) @(posedge clk);
        #1 check_output("hit count 1011", hit0, 6);
        repeat (3) @(posedge clk);
        #1 check_output("hit hold idle", hit0, 6);

        // Asynchronous reset mid-transfer.
        apply_stimulus(0, 16'h02E7, 5'd10, 8'd0, 1'b0, acc);
        push_rep(0, 16'h02E7 >> 7, 3, acc);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_output("midreset busy",    mb[0], 0);
        check_output("midreset x_valid", mv[0], 0);
        check_output("midreset ready",   sr[0], 1);
        check_output("midreset hit",     hit0,  0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 check_output("midreset drain", sb.size(), 0);

        // Repeat with a two-cycle gap.
        apply_stimulus(1, 16'h000D, 5'd4, 8'd2, 1'b0, acc);
        push_rep(1, 16'h000D, 4, acc);
        push_rep(1, 16'h000D, 4, acc + 6);
        push_rep(1, 16'h000D, 4, acc + 12);
        push_done(1, acc + 16);
        repeat (17) @(posedge clk);
        #1 check_output("gap ready", sr[1], 1);
        check_output("gap drain", sb.size(), 0);

        // Saturation of the 2-bit counter with z held high, then clear on the next accept.
        apply_stimulus(2, 16'h01AB, 5'd9, 8'd0, 1'b0, acc);
        push_rep(2, 16'h01AB, 9, acc);
        push_done(2, acc + 9);
        repeat (10) @(posedge clk);
        #1 check_output("sat hit", hit2, 3);
        apply_stimulus(2, 16'h0005, 5'd3, 8'd1, 1'b0, acc);
        check_output("hit clear on accept", hit2, 0);
        push_rep(2, 16'h0005, 3, acc);
        push_rep(2, 16'h0005, 3, acc + 3);
        push_done(2, acc + 6);
        repeat (7) @(posedge clk);
        #1 check_output("sat hit again", hit2, 3);
        check_output("final drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm_seq_generator.md
# fsm_seq_generator

Serial pattern transmitter that drives the single-bit `x` input of the team's FSM sequence detectors. A host loads a pattern word, length and repeat count through a valid/ready start handshake. The block shifts the pattern out MSB-first, one bit per clock, with an optional idle gap between repetitions. While a transfer runs, it counts detector hits on the returned `z` line, so a directed or self-checking bench closes the loop in hardware.

## Interface
- `WIDTH`, 16: maximum pattern length in bits.
- `LEN_W`, 5: width of `pat_len`; must hold the value `WIDTH`.
- `CNT_W`, 8: width of `rep` and `hit_cnt`.
- `GAP`, 0: idle cycles inserted between repetitions (0 = back-to-back).

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `start_valid` input 1: host request to start a transfer.
- `start_ready` output 1: high only in IDLE.
- `pat_data` input WIDTH: pattern; only bits [pat_len-1:0] are used.
- `pat_len` input LEN_W: number of bits to send.
  - 0 or any value above WIDTH is treated as WIDTH.
- `rep` input CNT_W: number of transmissions minus one.
- `abort` input 1: synchronous cancel of the current transfer.
- `z` input 1: detector output being monitored.
- `x` output 1: serial data bit.
- `x_valid` output 1: high in cycles where `x` carries a pattern bit.
- `busy` output 1: high in SHIFT, GAP and DONE.
- `done` output 1: one-cycle pulse marking normal completion.
- `hit_cnt` output CNT_W: saturating count of `z`=1 cycles during a transfer.

## Operation
- States are IDLE, SHIFT, GAP and DONE. Transitions:
  - IDLE→SHIFT on start accept (`start_valid & start_ready`).
  - SHIFT→SHIFT while bits remain in the current repetition.
  - SHIFT→GAP at the last bit when repetitions remain and GAP>0.
  - SHIFT→SHIFT (reload) at the last bit when repetitions remain and GAP=0.
  - SHIFT→DONE at the last bit of the last repetition.
  - GAP→SHIFT after GAP cycles.
  - DONE→IDLE unconditionally.
- On accept, the block captures `pat_data`, the effective length L and `rep`. Inputs may change afterwards without effect.
- Each repetition emits `pat_data[L-1]` down to `pat_data[0]`. The pattern register is reloaded from the captured copy for every repetition.
- Total transmissions = `rep`+1. The repetition counter decrements at the last bit of each repetition.
- In IDLE, GAP and DONE, `x`=0 and `x_valid`=0.
- `hit_cnt`:
  - Cleared to 0 on start accept.
  - Increments on every clock with `z`=1 while `busy`=1.
  - Holds at 2^CNT_W−1 once saturated.
  - Holds its value in IDLE until the next accept.
  - DONE is counted so that a registered (Moore) detector's response to the last bit is captured.
- `abort`=1 in any non-IDLE state forces IDLE on the next edge. No `done` pulse is produced, and `hit_cnt` keeps its value. `abort` is ignored in IDLE. If `abort` and `start_valid` are both high in IDLE, the start is accepted.
- `start_valid` is ignored outside IDLE, and `start_ready` stays 0 there.

## Timing
- Reset (`rst`=0, asynchronous) values:
  - State = IDLE; `x`=0, `x_valid`=0, `busy`=0, `done`=0, `hit_cnt`=0.
  - `start_ready`=1.
  - All internal counters = 0.
- `x`, `x_valid`, `busy` and `done` are registered outputs.
- `start_ready` is decoded directly from state == IDLE.
- Accept at edge N. The first bit appears on `x` with `x_valid`=1 in cycle N+1.
- Repetition k (k=0..rep) occupies L cycles, followed by GAP idle cycles if k<rep.
- Total busy cycles = (rep+1)·L + rep·GAP + 1, where the final +1 is the DONE cycle.
- `done` is high in the DONE cycle, which immediately follows the last bit. `start_ready` returns to 1 in the following cycle.
- Minimum spacing from one accept to the next is busy cycles + 1.
- Asserting `rst` mid-transfer clears everything immediately, with no `done` pulse. Release is synchronous to the next rising edge.

## Test plan
- Reset: hold `rst`=0 during clock activity, then release.
  - Required: all outputs at reset values and `start_ready`=1.
  - A `start_valid` in the first post-reset cycle is accepted.
- Single shot: `pat_data`=10'b1011100111, `pat_len`=10, `rep`=0, GAP=0.
  - `x` = 1,0,1,1,1,0,0,1,1,1 in cycles N+1..N+10 with `x_valid`=1.
  - `done`=1 in N+11 only; `start_ready`=1 in N+12.
- Repeat with gap: `pat_data`=4'b1101, `pat_len`=4, `rep`=2, GAP=2.
  - `x_valid` pattern: 1111 00 1111 00 1111, each burst carrying 1,1,0,1.
  - `done` at N+17.
- Length clamp: `pat_len`=0 with WIDTH=16, and separately `pat_len`=20.
  - Required in both cases: 16 bits are sent, `done` at N+17.
- Abort: assert `abort` at the 3rd bit of the single-shot case.
  - Required: IDLE next cycle, `x_valid`=0, no `done` pulse, `start_ready`=1.
  - A new start is then accepted normally.
- Hit counting: loop `x`→detector→`z` with a detector for 1011 and pattern 10'b1011011011, `rep`=1.
  - `hit_cnt`=6 after `done`.
  - With CNT_W=2 and forced `z`=1 for 10 busy cycles, `hit_cnt` saturates at 3.
